// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: walks a frame in raster order and offers one pixel job at
// a time to a rotating set of up to four cores. Each accepted job is followed
// by a one-cycle bubble, so a single core sees at most one job every two cycles.
module pixel_dispatcher #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 10
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         no_of_extra_cores,
  input  logic [3:0]         job_ready,
  output logic [3:0]         job_valid,
  output logic [COORD_W-1:0] job_x,
  output logic [COORD_W-1:0] job_y,
  output logic               job_sof,
  output logic               job_eol,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] ZERO_C = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

  state_t             r_state;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [1:0]         r_core;
  logic [2:0]         r_n;
  logic [3:0]         r_valid;
  logic               r_sof;
  logic               r_eol;
  logic               r_busy;
  logic               r_frame_done;

  state_t             w_state_nxt;
  logic [COORD_W-1:0] w_x_nxt;
  logic [COORD_W-1:0] w_y_nxt;
  logic [1:0]         w_core_nxt;
  logic [2:0]         w_n_nxt;
  logic [3:0]         w_valid_nxt;
  logic               w_sof_nxt;
  logic               w_eol_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_accept;
  logic               w_last;

  // One-hot core select for the job offer.
  function automatic logic [3:0] f_onehot(input logic [1:0] core);
    f_onehot = 4'b0001 << core;
  endfunction

  // Only the currently addressed core's ready bit counts, and only while offering.
  assign w_accept = job_ready[r_core] && (r_valid != 4'b0000);
  assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);

  // Next-state and next-output computation.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_core_nxt  = r_core;
    w_n_nxt     = r_n;
    w_valid_nxt = 4'b0000;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_ISSUE;
          w_n_nxt     = (no_of_extra_cores > 3'd3) ? 3'd4 : (no_of_extra_cores + 3'd1);
          w_x_nxt     = ZERO_C;
          w_y_nxt     = ZERO_C;
          w_core_nxt  = 2'd0;
          w_valid_nxt = f_onehot(2'd0);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = ZERO_C;
          w_y_nxt     = ZERO_C;
          w_core_nxt  = 2'd0;
        end else if (r_valid == 4'b0000) begin
          // Bubble cycle after an accept: present the next pixel.
          w_valid_nxt = f_onehot(r_core);
        end else if (w_accept) begin
          w_core_nxt = (({1'b0, r_core} + 3'd1) == r_n) ? 2'd0 : (r_core + 2'd1);
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_x_nxt     = ZERO_C;
            w_y_nxt     = ZERO_C;
            w_core_nxt  = 2'd0;
          end else if (r_x == X_LAST) begin
            w_x_nxt = ZERO_C;
            w_y_nxt = r_y + ONE_C;
          end else begin
            w_x_nxt = r_x + ONE_C;
          end
        end else begin
          w_valid_nxt = r_valid;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_x_nxt     = ZERO_C;
        w_y_nxt     = ZERO_C;
        w_core_nxt  = 2'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_x_nxt     = ZERO_C;
        w_y_nxt     = ZERO_C;
        w_core_nxt  = 2'd0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_sof_nxt  = (w_x_nxt == ZERO_C) && (w_y_nxt == ZERO_C) && (w_valid_nxt != 4'b0000);
    w_eol_nxt  = (w_x_nxt == X_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_x          <= ZERO_C;
      r_y          <= ZERO_C;
      r_core       <= 2'd0;
      r_n          <= 3'd1;
      r_valid      <= 4'b0000;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_core       <= w_core_nxt;
      r_n          <= w_n_nxt;
      r_valid      <= w_valid_nxt;
      r_sof        <= w_sof_nxt;
      r_eol        <= w_eol_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign job_valid  = r_valid;
  assign job_x      = r_x;
  assign job_y      = r_y;
  assign job_sof    = r_sof;
  assign job_eol    = r_eol;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher: a pixel-index reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pixel_dispatcher;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          abort;
  logic [2:0]    nec;
  logic [3:0]    ready;
  logic [3:0]    job_valid;
  logic [CW-1:0] job_x;
  logic [CW-1:0] job_y;
  logic          job_sof;
  logic          job_eol;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_errors = 0;

  pixel_dispatcher #(.H_RES(H), .V_RES(V), .COORD_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .no_of_extra_cores(nec), .job_ready(ready), .job_valid(job_valid),
    .job_x(job_x), .job_y(job_y), .job_sof(job_sof), .job_eol(job_eol),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 offering pixel k, 2 bubble, 3 frame done.
  int m_phase;
  int m_k;
  int m_n;

  // Model update from the protocol rules, in terms of the raster pixel index.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_phase <= 0;
      m_k     <= 0;
      m_n     <= 1;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
             m_phase <= 1;
             m_k     <= 0;
             m_n     <= (int'(nec) > 3) ? 4 : int'(nec) + 1;
           end
        1: if (abort) m_phase <= 0;
           else if (ready[m_k % m_n]) begin
             if (m_k == H * V - 1) m_phase <= 3;
             else begin
               m_k     <= m_k + 1;
               m_phase <= 2;
             end
           end
        2: m_phase <= abort ? 0 : 1;
        default: m_phase <= 0;
      endcase
    end
  end

  // Offer log and activity counters (written only by the compare process).
  int   lx[$];
  int   ly[$];
  int   lc[$];
  int   lsof[$];
  int   leol[$];
  int   busy_cnt = 0;
  int   done_cnt = 0;
  logic [3:0] prev_valid = 4'b0;

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge aclk) begin
    logic [3:0] ev;
    int core;
    ev = (m_phase == 1) ? (4'b0001 << (m_k % m_n)) : 4'b0000;
    chk("job_valid", 32'(job_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("frame_done", 32'(frame_done), 32'(m_phase == 3));
    if (ev != 4'b0000) begin
      chk("job_x", 32'(job_x), 32'(m_k % H));
      chk("job_y", 32'(job_y), 32'(m_k / H));
      chk("job_sof", 32'(job_sof), 32'(m_k == 0));
      chk("job_eol", 32'(job_eol), 32'((m_k % H) == H - 1));
    end
    if (job_valid != 4'b0000 && prev_valid == 4'b0000) begin
      core = 0;
      for (int i = 0; i < 4; i++) if (job_valid[i]) core = i;
      lx.push_back(int'(job_x));
      ly.push_back(int'(job_y));
      lc.push_back(core);
      lsof.push_back(int'(job_sof));
      leol.push_back(int'(job_eol));
    end
    if (busy) busy_cnt++;
    if (frame_done) done_cnt++;
    prev_valid = job_valid;
  end

  task automatic pulse_start();
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (frame_done) break;
    end
    chk({"done_timeout_", nm}, 32'(frame_done), 32'd1);
    repeat (2) @(negedge aclk);
  endtask

  int L0;
  int b0;
  int d0;
  int exp_c6[6];
  int exp_c8[8];

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; nec = 3'd0; ready = 4'b0;
    repeat (3) @(negedge aclk);
    chk("reset_outputs", {job_valid, job_x, job_y, job_sof, job_eol, busy, frame_done}, 32'd0);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Single core, always ready: raster order, two cycles per pixel.
    nec = 3'd0; ready = 4'b0001;
    L0 = lx.size(); b0 = busy_cnt; d0 = done_cnt;
    pulse_start();
    wait_done("t1");
    chk("t1_offers", 32'(lx.size() - L0), 32'd8);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd16);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_px5_x", 32'(lx[L0+5]), 32'd1);
    chk("t1_px5_y", 32'(ly[L0+5]), 32'd1);
    chk("t1_px7_core", 32'(lc[L0+7]), 32'd0);
    chk("t1_sof_first", 32'(lsof[L0]), 32'd1);
    chk("t1_sof_second", 32'(lsof[L0+1]), 32'd0);
    chk("t1_eol_x3", 32'(leol[L0+3]), 32'd1);
    chk("t1_eol_x2", 32'(leol[L0+2]), 32'd0);

    // Four cores, all ready: round-robin core assignment.
    nec = 3'd3; ready = 4'b1111;
    L0 = lx.size();
    pulse_start();
    wait_done("t2");
    exp_c6 = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) chk("t2_core_seq", 32'(lc[L0+i]), 32'(exp_c6[i]));

    // Out-of-range core count saturates; mid-frame change is ignored.
    nec = 3'd5;
    L0 = lx.size();
    pulse_start();
    repeat (2) @(negedge aclk);
    nec = 3'd1;
    wait_done("t3");
    exp_c8 = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) chk("t3_core_seq", 32'(lc[L0+i]), 32'(exp_c8[i]));

    // Stall core 1 for 10 cycles while other cores are ready.
    nec = 3'd3; ready = 4'b1111;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (job_valid == 4'b0010) break;
      @(negedge aclk);
    end
    chk("t4_reach_core1", 32'(job_valid), 32'h2);
    ready = 4'b1101;
    repeat (10) begin
      @(negedge aclk);
      chk("t4_stall_valid", 32'(job_valid), 32'h2);
      chk("t4_stall_x", 32'(job_x), 32'd1);
      chk("t4_stall_y", 32'(job_y), 32'd0);
    end
    ready = 4'b1111;
    wait_done("t4");

    // Abort together with ready, then restart.
    nec = 3'd1; ready = 4'b1111;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (job_valid != 4'b0000 && job_x == 4'd2) break;
      @(negedge aclk);
    end
    chk("t5_reach_x2", 32'(job_x), 32'd2);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge aclk); abort = 1'b0;
    chk("t5_abort_idle", {job_valid, busy, frame_done}, 32'd0);
    repeat (3) @(negedge aclk);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_start();
    chk("t5_restart", {job_valid, job_x, job_y}, {20'd0, 4'b0001, 4'd0, 4'd0});
    wait_done("t5");

    // Start asserted during the frame_done cycle is ignored.
    nec = 3'd0;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (frame_done) break;
    end
    chk("t6_saw_done", 32'(frame_done), 32'd1);
    start = 1'b1;
    @(negedge aclk); start = 1'b0;
    chk("t6_start_ignored", 32'(busy), 32'd0);
    repeat (2) @(negedge aclk);
    chk("t6_still_idle", {job_valid, busy}, 32'd0);

    // Asynchronous reset mid-frame discards the frame.
    nec = 3'd2;
    pulse_start();
    repeat (5) @(negedge aclk);
    d0 = done_cnt;
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    chk("t7_async_reset", {job_valid, job_x, job_y, job_sof, job_eol, busy, frame_done}, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    chk("t7_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t7_idle", 32'(busy), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 99) == 0);
      ready = 4'($urandom);
      nec   = 3'($urandom_range(0, 7));
    end
    @(negedge aclk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge aclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_dispatcher.md
PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 SHALL have parameter H_RES, default 640: pixels per line.
REQ-002 SHALL have parameter V_RES, default 480: lines per frame.
REQ-003 SHALL have parameter COORD_W, default 10: width of the x and y coordinate buses; H_RES and V_RES SHALL each be at most 2^COORD_W.
REQ-004 SHALL have port aclk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle frame start request.
REQ-007 SHALL have port abort, input, 1: synchronous frame abort.
REQ-008 SHALL have port no_of_extra_cores, input, 3: enabled cores minus one.
REQ-009 SHALL have port job_ready, input, 4: per-core accept; bit i belongs to core i.
REQ-010 SHALL have port job_valid, output, 4: one-hot job offer to core i.
REQ-011 SHALL have port job_x, output, COORD_W: pixel column of the offered job.
REQ-012 SHALL have port job_y, output, COORD_W: pixel row of the offered job.
REQ-013 SHALL have port job_sof, output, 1: high while the offered job is pixel (0,0).
REQ-014 SHALL have port job_eol, output, 1: high while job_x == H_RES-1.
REQ-015 SHALL have port busy, output, 1: high in ISSUE and DONE states.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse after the last pixel is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE and DONE; all outputs registered.
REQ-018 IDLE: on start, SHALL latch N = min(no_of_extra_cores,3)+1, clear x, y and cur_core to 0, and enter ISSUE the next cycle.
REQ-019 SHALL ignore no_of_extra_cores changes outside IDLE.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 ISSUE: job_valid SHALL equal one-hot(cur_core), and job_x/job_y/job_sof/job_eol SHALL describe the current pixel.
REQ-022 The offer SHALL hold stable until job_ready[cur_core]=1; job_ready bits of other cores SHALL be ignored.
REQ-023 On accept, job_valid SHALL drop for exactly one cycle, then the next pixel is offered; maximum throughput is one job per 2 cycles.
REQ-024 On accept, cur_core SHALL advance to (cur_core+1) mod N, so that pixel k goes to core k mod N, matching the in-order collection downstream.
REQ-025 On accept, x SHALL increment; at x = H_RES-1, x SHALL wrap to 0 and y SHALL increment.
REQ-026 On accept of pixel (H_RES-1, V_RES-1), the FSM SHALL enter DONE.
REQ-027 DONE: frame_done=1 for one cycle with job_valid=0, then the FSM SHALL return to IDLE.
REQ-028 A start in the DONE cycle SHALL be ignored.
REQ-029 abort in ISSUE or DONE SHALL force IDLE next cycle with job_valid=0, no frame_done, and counters cleared.
REQ-030 abort SHALL have priority over accept in the same cycle.
REQ-031 abort in IDLE SHALL have no effect.
REQ-032 Simultaneous start and abort in IDLE: abort wins; the block SHALL stay in IDLE.
REQ-033 Coordinate arithmetic SHALL be unsigned COORD_W-bit; counters SHALL never exceed H_RES-1 / V_RES-1.

Reset
REQ-034 While aresetn=0, SHALL hold state=IDLE, x=y=0, cur_core=0, N=1, job_valid=0, job_x=job_y=0, job_sof=0, job_eol=0, busy=0, frame_done=0.
REQ-035 Reset asserted mid-frame SHALL discard the frame immediately; no frame_done SHALL be produced.
REQ-036 After reset deassertion, the block SHALL remain in IDLE until the next start.

Verification
REQ-037 H_RES=4, V_RES=2, no_of_extra_cores=0, job_ready[0]=1 constantly, start -> 8 offers to core 0 in raster order (0,0)..(3,1), job_sof only on the first, job_eol on x=3, frame_done once, 2 cycles per pixel.
REQ-038 no_of_extra_cores=3, all job_ready=1 -> job_valid sequence 0001,0010,0100,1000,0001,... and pixel k goes to core k mod 4.
REQ-039 no_of_extra_cores=5 -> behaves as 4 cores; changing the input to 1 mid-frame -> still 4-core rotation.
REQ-040 job_ready[1] held low 10 cycles while core 1 is offered, with the other ready bits high -> offer and coordinates stable, no advance, no other core offered.
REQ-041 abort asserted together with job_ready in ISSUE -> IDLE next cycle, job_valid=0, no frame_done; a following start restarts at (0,0) on core 0.
REQ-042 aresetn pulsed low mid-frame -> all outputs 0 asynchronously; start held during the DONE cycle -> ignored.
